senzor_scan_ctrl: RTL and testbench

SENZOR_SCAN_CTRL -- requirements
Module: senzor_scan_ctrl

---
 rtl/senzor_scan_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_senzor_scan_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/senzor_scan_ctrl.sv
// Sensor scan controller: walks the enabled colour channels, issues one I2C register read per channel, and writes back the results.
// Optional WAIT-state watchdog enabled by defining SCAN_TIMEOUT_EN.
module senzor_scan_ctrl #(
    parameter logic [7:0] CH_REG_BASE    = 8'h08,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic        cfg_sd,
    input  logic [4:0]  cfg_ch_en,
    input  logic        cfg_endian,
    input  logic [6:0]  cfg_dev_addr,
    output logic        i2c_req,
    input  logic        i2c_ack,
    output logic [6:0]  i2c_dev_addr,
    output logic [7:0]  i2c_reg_addr,
    input  logic        i2c_done,
    input  logic        i2c_err,
    input  logic [15:0] i2c_rdata,
    output logic        i2c_abort,
    output logic        res_we,
    output logic [2:0]  res_sel,
    output logic [15:0] res_data,
    output logic        scan_done,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam int TIMER_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQ,
        S_WAIT,
        S_STORE,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [4:0]           ch_en_q, ch_en_d;
    logic                 endian_q, endian_d;
    logic [6:0]           dev_q, dev_d;

    logic                 req_d, res_we_d, scan_done_d, busy_d;
    logic [6:0]           dev_addr_d;
    logic [7:0]           reg_addr_d;
    logic [2:0]           res_sel_d;
    logic [15:0]          res_data_d;
    logic [7:0]           err_d;

    logic                 sel_found;
    logic [2:0]           sel_ch;
    logic [7:0]           err_inc;

`ifdef SCAN_TIMEOUT_EN
    logic                 abort_d;
`endif

    assign err_inc = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;

    // Lowest enabled snapshot channel at or above the pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = 4; i >= 0; i--) begin
            if (ch_en_q[i] && (3'(i) >= ptr_q)) begin
                sel_found = 1'b1;
                sel_ch    = 3'(i);
            end
        end
    end

    // Next state plus the next value of every registered output.
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        ch_en_d     = ch_en_q;
        endian_d    = endian_q;
        dev_d       = dev_q;
        dev_addr_d  = i2c_dev_addr;
        reg_addr_d  = i2c_reg_addr;
        res_sel_d   = res_sel;
        res_data_d  = res_data;
        err_d       = err_cnt;
        scan_done_d = 1'b0;
`ifdef SCAN_TIMEOUT_EN
        abort_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (scan_en && !cfg_sd && |cfg_ch_en) begin
                    ch_en_d  = cfg_ch_en;
                    endian_d = cfg_endian;
                    dev_d    = cfg_dev_addr;
                    ptr_d    = '0;
                    state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (cfg_sd) begin
                    state_d = S_IDLE;
                end else if (sel_found) begin
                    ptr_d      = sel_ch;
                    dev_addr_d = dev_q;
                    reg_addr_d = CH_REG_BASE + {4'b0000, sel_ch, 1'b0};
                    state_d    = S_REQ;
                end else begin
                    scan_done_d = 1'b1;
                    timer_d     = '0;
                    state_d     = S_GAP;
                end
            end
            S_REQ: begin
                if (i2c_ack) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i2c_done) begin
                    if (i2c_err) begin
                        err_d   = err_inc;
                        ptr_d   = ptr_q + 3'd1;
                        state_d = cfg_sd ? S_IDLE : S_SELECT;
                    end else begin
                        res_sel_d  = ptr_q;
                        res_data_d = endian_q ? {i2c_rdata[7:0], i2c_rdata[15:8]} : i2c_rdata;
                        state_d    = S_STORE;
                    end
                end
`ifdef SCAN_TIMEOUT_EN
                else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    abort_d = 1'b1;
                    err_d   = err_inc;
                    ptr_d   = ptr_q + 3'd1;
                    state_d = cfg_sd ? S_IDLE : S_SELECT;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
`endif
            end
            S_STORE: begin
                ptr_d   = ptr_q + 3'd1;
                state_d = cfg_sd ? S_IDLE : S_SELECT;
            end
            S_GAP: begin
                if (timer_q == TIMER_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_d    = (state_d == S_REQ);
        res_we_d = (state_d == S_STORE);
        busy_d   = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            timer_q      <= '0;
            ch_en_q      <= '0;
            endian_q     <= 1'b0;
            dev_q        <= '0;
            i2c_req      <= 1'b0;
            i2c_dev_addr <= '0;
            i2c_reg_addr <= '0;
            res_we       <= 1'b0;
            res_sel      <= '0;
            res_data     <= '0;
            scan_done    <= 1'b0;
            busy         <= 1'b0;
            err_cnt      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            timer_q      <= timer_d;
            ch_en_q      <= ch_en_d;
            endian_q     <= endian_d;
            dev_q        <= dev_d;
            i2c_req      <= req_d;
            i2c_dev_addr <= dev_addr_d;
            i2c_reg_addr <= reg_addr_d;
            res_we       <= res_we_d;
            res_sel      <= res_sel_d;
            res_data     <= res_data_d;
            scan_done    <= scan_done_d;
            busy         <= busy_d;
            err_cnt      <= err_d;
        end
    end

`ifdef SCAN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            i2c_abort <= 1'b0;
        end else begin
            i2c_abort <= abort_d;
        end
    end
`else
    assign i2c_abort = 1'b0;
`endif

endmodule

// File: tb/tb_senzor_scan_ctrl.sv
// Bench for senzor_scan_ctrl: the bench plays the I2C master, a scoreboard of expected requests/results
// checks every request and result cycle, and directed checks pin latency, counts and literal values.
module tb_senzor_scan_ctrl;

    localparam int GAP = 4;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_en, cfg_sd, cfg_endian;
    logic [4:0]  cfg_ch_en;
    logic [6:0]  cfg_dev_addr;
    logic        i2c_req, i2c_ack, i2c_done, i2c_err, i2c_abort;
    logic [6:0]  i2c_dev_addr;
    logic [7:0]  i2c_reg_addr;
    logic [15:0] i2c_rdata;
    logic        res_we, scan_done, busy;
    logic [2:0]  res_sel;
    logic [15:0] res_data;
    logic [7:0]  err_cnt;

    senzor_scan_ctrl #(
        .CH_REG_BASE   (8'h08),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
        .cfg_sd      (cfg_sd),
        .cfg_ch_en   (cfg_ch_en),
        .cfg_endian  (cfg_endian),
        .cfg_dev_addr(cfg_dev_addr),
        .i2c_req     (i2c_req),
        .i2c_ack     (i2c_ack),
        .i2c_dev_addr(i2c_dev_addr),
        .i2c_reg_addr(i2c_reg_addr),
        .i2c_done    (i2c_done),
        .i2c_err     (i2c_err),
        .i2c_rdata   (i2c_rdata),
        .i2c_abort   (i2c_abort),
        .res_we      (res_we),
        .res_sel     (res_sel),
        .res_data    (res_data),
        .scan_done   (scan_done),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [6:0] dev;
    } req_t;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
    } res_t;

    req_t        exp_req[$];
    res_t        exp_res[$];
    logic [7:0]  req_log[$];
    logic [15:0] res_log[$];
    logic [2:0]  sel_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_we     = 0;
    int n_abort  = 0;
    int cyc      = 0;
    int done_cyc = 0;
    int idle_cyc = 0;
    int m_err    = 0;
    bit m_endian = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every request and every result write is checked against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (i2c_req) begin
                check("req_expected", 32'(exp_req.size() != 0), 32'd1);
                if (exp_req.size() != 0) begin
                    check("req_dev_addr", 32'(i2c_dev_addr), 32'(exp_req[0].dev));
                    check("req_reg_addr", 32'(i2c_reg_addr), 32'(8'h08 + 2 * exp_req[0].ch));
                end
            end
            if (res_we) begin
                n_we++;
                res_log.push_back(res_data);
                sel_log.push_back(res_sel);
                check("res_expected", 32'(exp_res.size() != 0), 32'd1);
                if (exp_res.size() != 0) begin
                    check("res_sel", 32'(res_sel), 32'(exp_res[0].sel));
                    check("res_data", 32'(res_data), 32'(exp_res[0].data));
                    void'(exp_res.pop_front());
                end
            end
            if (scan_done) begin
                n_done++;
                done_cyc = cyc;
                check("done_all_requested", 32'(exp_req.size()), 32'd0);
            end
            if (i2c_abort) n_abort++;
        end
    end

    // Called at a negedge with the DUT idle; the model snapshots the configuration here.
    task automatic start_scan(input logic [4:0] en, input bit endian, input logic [6:0] dev, input bit lat);
        cfg_ch_en    = en;
        cfg_endian   = endian;
        cfg_dev_addr = dev;
        scan_en      = 1'b1;
        m_endian     = endian;
        for (int i = 0; i < 5; i++) begin
            if (en[i]) exp_req.push_back('{ch: i, dev: dev});
        end
        @(negedge clk);
        if (lat) begin
            check("lat_select_busy", 32'(busy), 32'd1);
            check("lat_select_noreq", 32'(i2c_req), 32'd0);
        end
        scan_en      = 1'b0;
        cfg_ch_en    = ~en;
        cfg_endian   = ~endian;
        cfg_dev_addr = ~dev;
        if (lat) begin
            @(negedge clk);
            check("lat_req_high", 32'(i2c_req), 32'd1);
        end
    endtask

    // Serve one request; delay < 0 means never complete it.
    task automatic do_txn(input bit err, input logic [15:0] data, input int delay, input bit sd);
        int   t = 0;
        int   ch = 7;
        req_t r;
        while (!i2c_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_seen", 32'(i2c_req), 32'd1);
        if (!i2c_req) return;
        req_log.push_back(i2c_reg_addr);
        i2c_ack = 1'b1;
        @(negedge clk);
        i2c_ack = 1'b0;
        check("req_drop_after_ack", 32'(i2c_req), 32'd0);
        if (exp_req.size() != 0) begin
            r  = exp_req.pop_front();
            ch = r.ch;
        end
        if (sd) cfg_sd = 1'b1;
        if (delay < 0) return;
        repeat (delay) @(negedge clk);
        i2c_done  = 1'b1;
        i2c_err   = err;
        i2c_rdata = data;
        if (err) m_err = (m_err >= 255) ? 255 : m_err + 1;
        else exp_res.push_back('{sel: 3'(ch), data: m_endian ? {data[7:0], data[15:8]} : data});
        @(negedge clk);
        i2c_done  = 1'b0;
        i2c_err   = 1'b0;
        i2c_rdata = 16'h0000;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        idle_cyc = cyc;
    endtask

    task automatic err_scans(input int n, input logic [4:0] en, input int nch);
        for (int s = 0; s < n; s++) begin
            start_scan(en, 1'b0, 7'h29, 1'b0);
            for (int k = 0; k < nch; k++) do_txn(1'b1, 16'h0000, 0, 1'b0);
            wait_idle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, done0, t;
        rst = 1'b1; scan_en = 1'b0; cfg_sd = 1'b0; cfg_endian = 1'b0;
        cfg_ch_en = '0; cfg_dev_addr = '0;
        i2c_ack = 1'b0; i2c_done = 1'b0; i2c_err = 1'b0; i2c_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(i2c_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(res_we), 32'd0);
        check("rst_done", 32'(scan_done), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_abort", 32'(i2c_abort), 32'd0);
        check("rst_reg_addr", 32'(i2c_reg_addr), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Three-channel scan, straight byte order, immediate ack/done.
        req_log.delete(); res_log.delete(); sel_log.delete();
        start_scan(5'b10101, 1'b0, 7'h29, 1'b1);
        repeat (3) do_txn(1'b0, 16'h1234, 0, 1'b0);
        wait_idle();
        check("s1_done_cnt", 32'(n_done), 32'd1);
        check("s1_we_cnt", 32'(n_we), 32'd3);
        check("s1_reg0", 32'(req_log[0]), 32'h08);
        check("s1_reg1", 32'(req_log[1]), 32'h0C);
        check("s1_reg2", 32'(req_log[2]), 32'h10);
        check("s1_sel1", 32'(sel_log[1]), 32'd2);
        check("s1_sel2", 32'(sel_log[2]), 32'd4);
        check("s1_data2", 32'(res_log[2]), 32'h1234);
        check("s1_gap_len", 32'(idle_cyc - done_cyc), 32'(GAP));
        check("s1_err_cnt", 32'(err_cnt), 32'd0);

        // Byte swap.
        res_log.delete();
        start_scan(5'b00001, 1'b1, 7'h44, 1'b0);
        do_txn(1'b0, 16'hA55A, 3, 1'b0);
        wait_idle();
        check("s2_swap", 32'(res_log[0]), 32'h5AA5);

        // Error on the middle of three channels.
        we0 = n_we;
        start_scan(5'b00111, 1'b0, 7'h29, 1'b0);
        do_txn(1'b0, 16'h1111, 0, 1'b0);
        do_txn(1'b1, 16'h2222, 1, 1'b0);
        do_txn(1'b0, 16'h3333, 2, 1'b0);
        wait_idle();
        check("s3_we_cnt", 32'(n_we - we0), 32'd2);
        check("s3_err_cnt", 32'(err_cnt), 32'd1);

        // Saturation of the error counter.
        err_scans(50, 5'b11111, 5);
        check("sat_251", 32'(err_cnt), 32'd251);
        err_scans(1, 5'b01111, 4);
        check("sat_255", 32'(err_cnt), 32'd255);
        err_scans(10, 5'b11111, 5);
        check("sat_hold", 32'(err_cnt), 32'd255);
        check("sat_model", 32'(err_cnt), 32'(m_err));

        // Shutdown during WAIT of the second channel.
        we0 = n_we; done0 = n_done;
        start_scan(5'b00111, 1'b0, 7'h12, 1'b0);
        do_txn(1'b0, 16'hAAAA, 0, 1'b0);
        do_txn(1'b0, 16'hBBBB, 1, 1'b1);
        exp_req.delete();
        wait_idle();
        repeat (4) @(negedge clk);
        check("sd_we_cnt", 32'(n_we - we0), 32'd2);
        check("sd_no_done", 32'(n_done - done0), 32'd0);
        check("sd_busy", 32'(busy), 32'd0);
        check("sd_no_req", 32'(i2c_req), 32'd0);
        cfg_sd = 1'b0;

        // i2c_done while idle is ignored.
        i2c_done = 1'b1; i2c_err = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0; i2c_err = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_done_ignored", 32'(err_cnt), 32'(m_err));

        // Reset while a request is pending.
        start_scan(5'b00011, 1'b0, 7'h29, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_drop", 32'(i2c_req), 32'd0);
        check("rst_req_busy", 32'(busy), 32'd0);
        check("rst_req_err", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        exp_req.delete(); exp_res.delete(); m_err = 0;
        cfg_ch_en = 5'b00000; scan_en = 1'b1;
        repeat (5) @(negedge clk);
        check("no_ch_idle_busy", 32'(busy), 32'd0);
        check("no_ch_idle_req", 32'(i2c_req), 32'd0);
        scan_en = 1'b0;
        @(negedge clk);

`ifdef SCAN_TIMEOUT_EN
        // Watchdog: first channel never completes.
        start_scan(5'b00011, 1'b0, 7'h29, 1'b0);
        do_txn(1'b0, 16'h0000, -1, 1'b0);
        t = 0;
        while (!i2c_abort && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("tmo_cycles", 32'(t), 32'(TMO));
        check("tmo_err_cnt", 32'(err_cnt), 32'd1);
        m_err = 1;
        req_log.delete();
        do_txn(1'b0, 16'h4242, 0, 1'b0);
        check("tmo_next_reg", 32'(req_log[0]), 32'h0A);
        wait_idle();
        check("tmo_abort_cnt", 32'(n_abort), 32'd1);
`else
        t = 0;
        check("no_abort", 32'(n_abort), 32'(t));
`endif
        check("res_queue_drained", 32'(exp_res.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
